// File: rtl/toaster_pkg.sv
// Shared types and constants for the toaster countdown timer.
// The BCD time word is {minutes, seconds tens, seconds units}.
package toaster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    // A preset is usable only if every digit is decimal and the seconds stay below 60.
    function automatic logic bcd_time_valid(input logic [11:0] t);
        return (bcd_t'(t[11:8]) <= DIGIT_MAX) &&
               (bcd_t'(t[7:4])  <= SEC_TENS_MAX) &&
               (bcd_t'(t[3:0])  <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler that emits a one-cycle tick every TICK_CYCLES enabled clocks.
// clr has priority over en and restarts the count at zero.
module tick_gen #(
    parameter int unsigned TICK_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             term_s;

    assign term_s = (cnt_q == TERM);
    assign tick   = en && !clr && term_s;

    // Next prescaler value: wraps on the terminal count so it never overflows.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (term_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/toast_timer.sv
// Toaster countdown timer: BCD m:ss preset, 1 s ticks, done/load_err pulses.
// FSM is IDLE -> RUN -> DONE; cancel returns to IDLE from anywhere.
module toast_timer
    import toaster_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] set_time,
    input  logic        load,
    input  logic        start,
    input  logic        cancel,
    output logic [11:0] tLED,
    output logic        running,
    output logic        done,
    output logic        load_err
);

    timer_state_t state_q;
    timer_state_t state_d;
    logic [11:0]  tled_q;
    logic [11:0]  tled_d;
    logic         running_q;
    logic         running_d;
    logic         done_q;
    logic         done_d;
    logic         load_err_q;
    logic         load_err_d;

    logic         tick_s;
    logic         run_s;
    logic         set_ok_s;
    logic [11:0]  dec_s;

    // One-second decrement with BCD borrow from units to tens to minutes.
    function automatic logic [11:0] bcd_time_dec(input logic [11:0] t);
        bcd_t mins;
        bcd_t tens;
        bcd_t units;
        logic borrow_u;
        logic borrow_t;
        mins  = t[11:8];
        tens  = t[7:4];
        units = t[3:0];
        if (units == 4'd0) begin
            units    = DIGIT_MAX;
            borrow_u = 1'b1;
        end else begin
            units    = units - 4'd1;
            borrow_u = 1'b0;
        end
        borrow_t = 1'b0;
        if (borrow_u) begin
            if (tens == 4'd0) begin
                tens     = SEC_TENS_MAX;
                borrow_t = 1'b1;
            end else begin
                tens     = tens - 4'd1;
            end
        end
        if (borrow_t) begin
            mins = mins - 4'd1;
        end
        return {mins, tens, units};
    endfunction

    assign run_s    = (state_q == ST_RUN);
    assign set_ok_s = bcd_time_valid(set_time);
    assign dec_s    = bcd_time_dec(tled_q);

    // The prescaler is held cleared outside RUN so each start begins a full second.
    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (!run_s),
        .en     (run_s),
        .tick   (tick_s)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tled_q     <= 12'h000;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tled_q     <= tled_d;
            running_q  <= running_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    // Next state and displayed time; cancel outranks load, load outranks start.
    always_comb begin
        state_d = state_q;
        tled_d  = tled_q;
        case (state_q)
            ST_IDLE: begin
                if (cancel) begin
                    tled_d = 12'h000;
                end else if (load) begin
                    if (set_ok_s) begin
                        tled_d = set_time;
                    end else begin
                        tled_d = tled_q;
                    end
                end else if (start && (tled_q != 12'h000)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    tled_d  = 12'h000;
                end else if (tick_s) begin
                    tled_d = dec_s;
                    if (dec_s == 12'h000) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    tled_d  = 12'h000;
                end else if (load && set_ok_s) begin
                    state_d = ST_IDLE;
                    tled_d  = set_time;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tled_d  = 12'h000;
            end
        endcase
    end

    // Output decode, registered so every output is glitch-free.
    always_comb begin
        running_d  = (state_d == ST_RUN);
        done_d     = run_s && !cancel && tick_s && (dec_s == 12'h000);
        load_err_d = !run_s && load && !cancel && !set_ok_s;
    end

    assign tLED     = tled_q;
    assign running  = running_q;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_toast_timer.sv
// Bench for toast_timer: directed scenarios plus random traffic against a
// seconds-based reference model.
module tb_toast_timer;

    localparam int TC = 4;

    logic        clk;
    logic        reset_n;
    logic [11:0] set_time;
    logic        load;
    logic        start;
    logic        cancel;
    logic [11:0] tLED;
    logic        running;
    logic        done;
    logic        load_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 idle, 1 counting, 2 finished; time kept in seconds.
    int m_mode;
    int m_secs;
    int m_elapsed;
    bit m_done;
    bit m_err;
    int done_seen;

    toast_timer #(.TICK_CYCLES(TC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .set_time(set_time),
        .load    (load),
        .start   (start),
        .cancel  (cancel),
        .tLED    (tLED),
        .running (running),
        .done    (done),
        .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit spec_valid(input logic [11:0] t);
        return (int'(t[11:8]) <= 9) && (int'(t[7:4]) <= 5) && (int'(t[3:0]) <= 9);
    endfunction

    function automatic int bcd_to_secs(input logic [11:0] t);
        return int'(t[11:8]) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    function automatic logic [11:0] secs_to_bcd(input int s);
        int r;
        r = s % 60;
        return {4'(s / 60), 4'(r / 10), 4'(r % 10)};
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_secs    = 0;
        m_elapsed = 0;
        m_done    = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic model_step(input bit ld, input bit st, input bit cn, input logic [11:0] sv);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (cn) begin
            m_mode = 0;
            m_secs = 0;
        end else if (m_mode == 0) begin
            if (ld) begin
                if (spec_valid(sv)) m_secs = bcd_to_secs(sv);
                else                m_err  = 1'b1;
            end else if (st && m_secs != 0) begin
                m_mode    = 1;
                m_elapsed = 0;
            end
        end else if (m_mode == 1) begin
            if (m_elapsed % TC == TC - 1) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_mode = 2;
                    m_done = 1'b1;
                end
            end
            m_elapsed++;
        end else begin
            if (ld) begin
                if (spec_valid(sv)) begin
                    m_mode = 0;
                    m_secs = bcd_to_secs(sv);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("tLED", 32'(tLED), 32'(secs_to_bcd(m_secs)));
        chk("running", 32'(running), 32'(m_mode == 1));
        chk("done", 32'(done), 32'(m_done));
        chk("load_err", 32'(load_err), 32'(m_err));
        if (done) done_seen++;
    endtask

    // One clock: inputs set at the falling edge, model and DUT advance on the rising edge.
    task automatic step_cycle(input bit ld, input bit st, input bit cn, input logic [11:0] sv);
        load     = ld;
        start    = st;
        cancel   = cn;
        set_time = sv;
        @(posedge clk);
        model_step(ld, st, cn, sv);
        #1;
        compare_all();
        @(negedge clk);
        load   = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step_cycle(1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tLED"}, 32'(tLED), 32'h0);
        chk({tag, "_running"}, 32'(running), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_load_err"}, 32'(load_err), 32'h0);
    endtask

    initial begin
        reset_n  = 1'b0;
        load     = 1'b0;
        start    = 1'b0;
        cancel   = 1'b0;
        set_time = 12'h000;
        model_reset();
        done_seen = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Full countdown from 1:05.
        step_cycle(1'b1, 1'b0, 1'b0, 12'h105);
        step_cycle(1'b0, 1'b1, 1'b0, 12'h000);
        done_seen = 0;
        for (int k = 1; k <= 270; k++) begin
            step_cycle(1'b0, 1'b0, 1'b0, 12'h000);
            if (k == 3)   chk("pre_tick", 32'(tLED), 32'h105);
            if (k == 4)   chk("t104", 32'(tLED), 32'h104);
            if (k == 24)  chk("t059", 32'(tLED), 32'h059);
            if (k == 259) chk("run_before_end", 32'(running), 32'h1);
            if (k == 260) begin
                chk("t000", 32'(tLED), 32'h000);
                chk("done_at_end", 32'(done), 32'h1);
                chk("run_fell", 32'(running), 32'h0);
            end
        end
        chk("done_count", 32'(done_seen), 32'h1);
        step_cycle(1'b0, 1'b1, 1'b0, 12'h000);
        chk("done_start_ignored", 32'(running), 32'h0);

        // Rejected presets leave the display alone.
        step_cycle(1'b0, 1'b0, 1'b1, 12'h000);
        step_cycle(1'b1, 1'b0, 1'b0, 12'h123);
        step_cycle(1'b1, 1'b0, 1'b0, 12'h07A);
        chk("err_07A", 32'(load_err), 32'h1);
        chk("keep_07A", 32'(tLED), 32'h123);
        step_cycle(1'b1, 1'b0, 1'b0, 12'h160);
        chk("err_160", 32'(load_err), 32'h1);
        chk("keep_160", 32'(tLED), 32'h123);
        idle_cycles(1);
        chk("err_one_cycle", 32'(load_err), 32'h0);

        // Start with nothing loaded is ignored.
        step_cycle(1'b0, 1'b0, 1'b1, 12'h000);
        step_cycle(1'b0, 1'b1, 1'b0, 12'h000);
        chk("start_zero_run", 32'(running), 32'h0);
        idle_cycles(8);

        // Cancel mid-count.
        step_cycle(1'b1, 1'b0, 1'b0, 12'h030);
        step_cycle(1'b0, 1'b1, 1'b0, 12'h000);
        idle_cycles(5);
        step_cycle(1'b0, 1'b0, 1'b1, 12'h000);
        chk("cancel_tLED", 32'(tLED), 32'h000);
        chk("cancel_run", 32'(running), 32'h0);
        done_seen = 0;
        idle_cycles(150);
        chk("cancel_no_done", 32'(done_seen), 32'h0);

        // Reset mid-count.
        step_cycle(1'b1, 1'b0, 1'b0, 12'h010);
        step_cycle(1'b0, 1'b1, 1'b0, 12'h000);
        idle_cycles(4);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0;
        idle_cycles(60);
        chk("rst_no_done", 32'(done_seen), 32'h0);

        // Load/start during RUN are ignored; load in DONE returns to IDLE.
        step_cycle(1'b1, 1'b0, 1'b0, 12'h012);
        step_cycle(1'b0, 1'b1, 1'b0, 12'h000);
        idle_cycles(6);
        step_cycle(1'b1, 1'b1, 1'b0, 12'h999);
        chk("run_ignore_err", 32'(load_err), 32'h0);
        chk("run_ignore_tLED", 32'(tLED), 32'h011);
        idle_cycles(50);
        step_cycle(1'b1, 1'b0, 1'b0, 12'h020);
        chk("done_reload", 32'(tLED), 32'h020);
        chk("done_reload_run", 32'(running), 32'h0);

        // Simultaneous load and start in IDLE: load wins.
        step_cycle(1'b1, 1'b1, 1'b0, 12'h015);
        chk("ld_st_tLED", 32'(tLED), 32'h015);
        chk("ld_st_run", 32'(running), 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] sv;
            bit ld;
            bit st;
            bit cn;
            if ($urandom_range(0, 1) == 0)
                sv = {4'd0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            else
                sv = 12'($urandom);
            ld = ($urandom_range(0, 11) == 0);
            st = ($urandom_range(0, 5) == 0);
            cn = ($urandom_range(0, 79) == 0);
            step_cycle(ld, st, cn, sv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/toast_timer.md
TOAST_TIMER -- requirements
Module: toast_timer

Interface
REQ-001 Parameter TICK_CYCLES, default 50_000_000, is the number of clk cycles per 1 s countdown tick.
REQ-002 clk  input  1  system clock, single domain.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 set_time  input  12  BCD preset: [11:8] minutes, [7:4] seconds tens, [3:0] seconds units.
REQ-005 load  input  1  one-cycle request to capture set_time.
REQ-006 start  input  1  one-cycle request to begin countdown.
REQ-007 cancel  input  1  one-cycle request to abort and clear.
REQ-008 tLED  output  12  current remaining time in set_time's BCD format; feeds the time display driver.
REQ-009 running  output  1  high while counting down; drives the heater enable.
REQ-010 done  output  1  one-cycle pulse when the count reaches 0:00.
REQ-011 load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-012 States: IDLE, RUN, DONE; running = (state == RUN).
REQ-013 IDLE + load + valid set_time -> tLED <= set_time on the next edge; state stays IDLE.
REQ-014 Valid set_time: every nibble <= 9 and [7:4] <= 5; otherwise tLED is unchanged and load_err pulses the next cycle.
REQ-015 IDLE + start + tLED != 0x000 -> RUN next cycle; prescaler cleared to 0.
REQ-016 IDLE + start + tLED == 0x000: start is ignored, no state change.
REQ-017 In RUN, the prescaler counts 0..TICK_CYCLES-1 and issues a tick on terminal count; the first tick comes TICK_CYCLES cycles after the start-capturing edge.
REQ-018 Tick decrement: units 0 -> 9 with borrow, else -1; tens 0 -> 5 with borrow, else -1; minutes -1 on borrow.
REQ-019 A tick that produces 0x000 moves the FSM to DONE on the same edge; done is high exactly the following cycle.
REQ-020 In DONE: tLED holds 0x000, running is low, start is ignored; load (valid) returns to IDLE with the new value, cancel returns to IDLE.
REQ-021 load and start in RUN are ignored; load_err does not pulse for them.
REQ-022 cancel in any state -> IDLE and tLED = 0x000 next edge; cancel beats simultaneous load/start.
REQ-023 Simultaneous load and start in IDLE: load takes effect; start is ignored.
REQ-024 Prescaler width = clog2(TICK_CYCLES); no arithmetic overflow beyond the terminal count.

Reset
REQ-025 reset_n low forces state IDLE, tLED 0x000, prescaler 0, running 0, done 0, load_err 0, asynchronously.
REQ-026 Reset asserted mid-RUN aborts the countdown; no done pulse after release.

Structure
REQ-027 Shared package toaster_pkg holds the state enum timer_state_t, the BCD nibble typedef bcd_t, and the constants SEC_TENS_MAX = 5 and DIGIT_MAX = 9.
REQ-028 One sub-module, tick_gen (prescaler with clear and enable, one-cycle tick output), is instantiated; the BCD decrement and the FSM stay in toast_timer.

Verification (TICK_CYCLES = 4)
REQ-029 Load 0x105, start -> tLED 104 at +4 cycles, 059 at +24, 000 at +260; done pulses once; running falls with it.
REQ-030 Load 0x07A and load 0x160 -> each load_err pulses; tLED keeps its prior value.
REQ-031 Start with tLED = 000 -> stays IDLE, running 0, no done.
REQ-032 Load 0x030, start, cancel at +6 cycles -> IDLE, tLED 000, running 0, no done.
REQ-033 Load 0x010, start, drop reset_n at +5 cycles -> all outputs 0 immediately; no done after release.
REQ-034 In RUN, pulse load with 0x999 and start -> ignored, countdown continues unchanged; in DONE, load 0x020 -> IDLE with tLED 020.
